// File: rtl/cdr_pkg.sv
// cdr_pkg
// Shared definitions for the clock-recovery lock sequencer.
//   - cdr_state_e : sequencer state encoding, also driven on state_o
//   - *_DEF       : default widths and tolerances used by the top and checker
//   - sat_add     : addition that clamps at the all-ones value of a given width
//   - sat_sub     : subtraction that floors at zero
// Optional feature macro used by the files that import this package: CDR_TRACK_EN
package cdr_pkg;

    localparam int CLK_LEN_DEF = 32;
    localparam int TOL_DEF     = 2;
    localparam int MAX_RUN_DEF = 8;

    // Widest value the saturating helpers operate on; callers zero-extend
    // into this width and cast the result back to their own width.
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } cdr_state_e;

    // Adds a and b and clamps to (2**width)-1 so that a narrow register
    // holding the result never wraps around.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int width);
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] lim;
        lim = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[MAX_W-1:0];
    endfunction

    // Subtracts b from a, returning zero instead of wrapping.
    function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/cdr_run_checker.sv
// cdr_run_checker
// Classifies one measured edge-to-edge interval against the current bit period.
// The interval is reduced by repeated subtraction of the period until the
// residue falls inside the upper tolerance; the interval is good when that
// residue is within +/-TOL of one period and the number of bit periods it
// spans does not exceed MAX_RUN.
// Ports:
//   clk_300M, rst : clock and asynchronous active-high reset
//   clear         : abandon any check in progress (held while not checking)
//   start         : begin a new check with interval/period (overrides a busy check)
//   interval      : measured edge-to-edge interval in ticks
//   period        : current bit period estimate in ticks
//   busy          : a check is in progress
//   done          : the check finishes this cycle; good is valid
//   good          : verdict of the finishing check
//   res_fast/slow : (CDR_TRACK_EN only) finishing single-run check whose
//                   residue lies above/below the period
module cdr_run_checker
    import cdr_pkg::*;
#(
    parameter int CLK_LEN = CLK_LEN_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic               clk_300M,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic [CLK_LEN-1:0] interval,
    input  logic [CLK_LEN-1:0] period,
    output logic               busy,
    output logic               done,
`ifdef CDR_TRACK_EN
    output logic               res_fast,
    output logic               res_slow,
`endif
    output logic               good
);

    logic [CLK_LEN-1:0] residue_q, residue_d;
    logic [CLK_LEN-1:0] runs_q, runs_d;
    logic               busy_q, busy_d;
    logic [MAX_W-1:0]   hi_w, lo_w;
    logic               over;

    // The tolerance window is evaluated in the wide helper width so the
    // upper bound can clamp at all-ones and the lower bound at zero. While
    // the residue sits above the window another whole period is peeled off;
    // since that only happens when residue > period+TOL the subtraction
    // cannot underflow. The run counter saturates so a degenerate period
    // cannot make it wrap back into the legal range.
    always_comb begin
        hi_w      = sat_add(MAX_W'(period), MAX_W'(TOL), CLK_LEN);
        lo_w      = sat_sub(MAX_W'(period), MAX_W'(TOL));
        over      = MAX_W'(residue_q) > hi_w;
        residue_d = residue_q;
        runs_d    = runs_q;
        busy_d    = busy_q;
        if (clear) begin
            busy_d = 1'b0;
        end else if (start) begin
            residue_d = interval;
            runs_d    = CLK_LEN'(1);
            busy_d    = 1'b1;
        end else if (busy_q) begin
            if (over) begin
                residue_d = residue_q - period;
                runs_d    = CLK_LEN'(sat_add(MAX_W'(runs_q), MAX_W'(1), CLK_LEN));
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    // A check finishes in the first busy cycle whose residue is no longer
    // above the window, so the verdict only needs the lower bound and the
    // run-length limit.
    always_comb begin
        done = busy_q && !over;
        good = done && (MAX_W'(residue_q) >= lo_w) && (runs_q <= CLK_LEN'(MAX_RUN));
`ifdef CDR_TRACK_EN
        res_fast = good && (runs_q == CLK_LEN'(1)) && (residue_q > period);
        res_slow = good && (runs_q == CLK_LEN'(1)) && (residue_q < period);
`endif
    end

    assign busy = busy_q;

    // Reset drops any check in flight immediately.
    always_ff @(posedge clk_300M or posedge rst) begin
        if (rst) begin
            residue_q <= '0;
            runs_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            residue_q <= residue_d;
            runs_q    <= runs_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: rtl/cdr_lock_sequencer.sv
// cdr_lock_sequencer
// Acquisition and lock controller for the bit-clock recovery datapath.
// Acquires the bit period as the shortest non-glitch interval seen over a
// window of edges, verifies it against a run of consecutive edges, holds lock
// while edges keep fitting, and re-acquires after losing lock or timing out.
// Optional macro CDR_TRACK_EN: while locked, nudge period_est by one tick
// after a net drift of eight single-run residues in the same direction.
// Ports:
//   clk_300M      : 300 MHz clock shared with the datapath
//   rst           : asynchronous active-high reset
//   enable        : 0 forces IDLE
//   edge_stb      : one-cycle strobe per detected falling edge
//   edge_interval : ticks since the previous edge, valid with edge_stb
//   period_est    : bit period handed to the recovery NCO
//   est_clear     : one-cycle pulse asking the datapath to resync its phase
//   locked        : lock indicator
//   state_o       : current state encoding
//   loss_count    : saturating count of lock-loss events
module cdr_lock_sequencer
    import cdr_pkg::*;
#(
    parameter int CLK_LEN      = CLK_LEN_DEF,
    parameter int ACQ_EDGES    = 64,
    parameter int MIN_INTERVAL = 4,
    parameter int TOL          = TOL_DEF,
    parameter int MAX_RUN      = MAX_RUN_DEF,
    parameter int LOCK_EDGES   = 16,
    parameter int MISS_LIMIT   = 4,
    parameter int TIMEOUT      = 1048576
) (
    input  logic               clk_300M,
    input  logic               rst,
    input  logic               enable,
    input  logic               edge_stb,
    input  logic [CLK_LEN-1:0] edge_interval,
    output logic [CLK_LEN-1:0] period_est,
    output logic               est_clear,
    output logic               locked,
    output logic [2:0]         state_o,
    output logic [7:0]         loss_count
);

    localparam int ACQ_W  = $clog2(ACQ_EDGES + 1);
    localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
    localparam int BAD_W  = $clog2(MISS_LIMIT + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    cdr_state_e         state_q, state_d;
    logic [CLK_LEN-1:0] period_est_q, period_est_d;
    logic [CLK_LEN-1:0] min_q, min_d, new_min;
    logic               est_clear_q, est_clear_d;
    logic               locked_q, locked_d;
    logic [7:0]         loss_count_q, loss_count_d;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d, acq_next;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d, good_next;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d, bad_next;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
`ifdef CDR_TRACK_EN
    logic signed [4:0]  trend_q, trend_d;
    logic               chk_fast, chk_slow;
`endif

    logic in_check, chk_start, chk_clear, chk_busy, chk_done, chk_good;
    logic abort, res_valid, res_good, timeout_hit, go_acq, go_lost;

    // The checker only runs while the period is being verified or tracked;
    // in every other state it is held clear so a stale check cannot leak a
    // verdict into the next verify phase.
    assign in_check  = (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
    assign chk_start = edge_stb && in_check;
    assign chk_clear = !in_check;

    cdr_run_checker #(
        .CLK_LEN (CLK_LEN),
        .TOL     (TOL),
        .MAX_RUN (MAX_RUN)
    ) u_checker (
        .clk_300M (clk_300M),
        .rst      (rst),
        .clear    (chk_clear),
        .start    (chk_start),
        .interval (edge_interval),
        .period   (period_est_q),
        .busy     (chk_busy),
        .done     (chk_done),
`ifdef CDR_TRACK_EN
        .res_fast (chk_fast),
        .res_slow (chk_slow),
`endif
        .good     (chk_good)
    );

    // A new edge arriving while a check is still iterating aborts it; that
    // abort is itself a verdict and always a bad one.
    always_comb begin
        abort       = edge_stb && chk_busy && in_check;
        res_valid   = in_check && (chk_done || abort);
        res_good    = chk_done && chk_good && !abort;
        timeout_hit = idle_cnt_q >= IDLE_W'(TIMEOUT);
        acq_next    = acq_cnt_q + ACQ_W'(1);
        good_next   = good_cnt_q + GOOD_W'(1);
        bad_next    = bad_cnt_q + BAD_W'(1);
        new_min     = (edge_interval < min_q) ? edge_interval : min_q;
    end

    // Next-state logic. Timeouts are tested before check results in each
    // state so a timeout always wins a same-cycle verdict. Every entry into
    // ACQUIRE goes through go_acq so the window, the counters and the phase
    // resync pulse are handled identically whatever caused the restart.
    always_comb begin
        state_d      = state_q;
        period_est_d = period_est_q;
        min_d        = min_q;
        est_clear_d  = 1'b0;
        locked_d     = locked_q;
        loss_count_d = loss_count_q;
        acq_cnt_d    = acq_cnt_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        idle_cnt_d   = edge_stb ? '0 :
                       (timeout_hit ? idle_cnt_q : idle_cnt_q + IDLE_W'(1));
`ifdef CDR_TRACK_EN
        trend_d      = trend_q;
`endif
        go_acq       = 1'b0;
        go_lost      = 1'b0;

        if (!enable) begin
            state_d    = ST_IDLE;
            locked_d   = 1'b0;
            min_d      = '1;
            acq_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            idle_cnt_d = '0;
`ifdef CDR_TRACK_EN
            trend_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    go_acq = 1'b1;
                end
                ST_ACQUIRE: begin
                    if (timeout_hit) begin
                        go_acq = 1'b1;
                    end else if (edge_stb && (edge_interval >= CLK_LEN'(MIN_INTERVAL))) begin
                        min_d     = new_min;
                        acq_cnt_d = acq_next;
                        if (acq_next == ACQ_W'(ACQ_EDGES)) begin
                            period_est_d = new_min;
                            est_clear_d  = 1'b1;
                            good_cnt_d   = '0;
                            bad_cnt_d    = '0;
                            state_d      = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (timeout_hit) begin
                        go_acq = 1'b1;
                    end else if (res_valid) begin
                        if (res_good) begin
                            good_cnt_d = good_next;
                            if (good_next == GOOD_W'(LOCK_EDGES)) begin
                                state_d   = ST_LOCKED;
                                locked_d  = 1'b1;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            good_cnt_d = '0;
                            bad_cnt_d  = bad_next;
                            if (bad_next == BAD_W'(MISS_LIMIT)) begin
                                go_acq = 1'b1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (timeout_hit) begin
                        go_lost = 1'b1;
                    end else if (res_valid) begin
                        if (res_good) begin
                            bad_cnt_d = '0;
`ifdef CDR_TRACK_EN
                            if (chk_fast) begin
                                if (trend_q == 5'sd7) begin
                                    period_est_d = CLK_LEN'(sat_add(MAX_W'(period_est_q), MAX_W'(1), CLK_LEN));
                                    trend_d      = '0;
                                end else begin
                                    trend_d = trend_q + 5'sd1;
                                end
                            end else if (chk_slow) begin
                                if (trend_q == -5'sd7) begin
                                    period_est_d = CLK_LEN'(sat_sub(MAX_W'(period_est_q), MAX_W'(1)));
                                    trend_d      = '0;
                                end else begin
                                    trend_d = trend_q - 5'sd1;
                                end
                            end
`endif
                        end else begin
                            bad_cnt_d = bad_next;
`ifdef CDR_TRACK_EN
                            trend_d   = '0;
`endif
                            if (bad_next == BAD_W'(MISS_LIMIT)) begin
                                go_lost = 1'b1;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    go_acq = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (go_lost) begin
                state_d      = ST_LOST;
                locked_d     = 1'b0;
                loss_count_d = 8'(sat_add(MAX_W'(loss_count_q), MAX_W'(1), 8));
            end

            if (go_acq) begin
                state_d     = ST_ACQUIRE;
                est_clear_d = 1'b1;
                locked_d    = 1'b0;
                min_d       = '1;
                acq_cnt_d   = '0;
                good_cnt_d  = '0;
                bad_cnt_d   = '0;
                idle_cnt_d  = '0;
`ifdef CDR_TRACK_EN
                trend_d     = '0;
`endif
            end
        end
    end

    // State and every output are registered here; period_est comes out of
    // reset as all-ones so the NCO sees no usable period before acquisition.
    always_ff @(posedge clk_300M or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            period_est_q <= '1;
            min_q        <= '1;
            est_clear_q  <= 1'b0;
            locked_q     <= 1'b0;
            loss_count_q <= '0;
            acq_cnt_q    <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            idle_cnt_q   <= '0;
`ifdef CDR_TRACK_EN
            trend_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            period_est_q <= period_est_d;
            min_q        <= min_d;
            est_clear_q  <= est_clear_d;
            locked_q     <= locked_d;
            loss_count_q <= loss_count_d;
            acq_cnt_q    <= acq_cnt_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
`ifdef CDR_TRACK_EN
            trend_q      <= trend_d;
`endif
        end
    end

    assign period_est = period_est_q;
    assign est_clear  = est_clear_q;
    assign locked     = locked_q;
    assign state_o    = state_q;
    assign loss_count = loss_count_q;

endmodule
